// File: rtl/bus_if_burst.sv
// Burst bus master: sends ADDR_BYTES address bytes then up to MAX_LEN data bytes,
// one four-phase req/ack handshake per byte, completing with a one-cycle done pulse.
module bus_if_burst #(
    parameter int unsigned ADDR_BYTES = 2,
    parameter int unsigned MAX_LEN    = 4,
    localparam int unsigned LW        = $clog2(MAX_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bus_handshake_ack,
    output logic                    bus_handshake_req,
    output logic [1:0]              bus_state,
    input  logic [7:0]              bus_data_in,
    output logic [7:0]              bus_data_out,
    output logic                    bus_output_enable,
    output logic                    bus_io,
    input  logic                    memory_read,
    input  logic                    memory_write,
    input  logic [8*ADDR_BYTES-1:0] memory_addr,
    input  logic                    memory_io,
    input  logic [LW-1:0]           memory_len,
    input  logic [8*MAX_LEN-1:0]    memory_wdata,
    output logic [8*MAX_LEN-1:0]    memory_rdata,
    output logic                    memory_done
);

    localparam int unsigned CNT_MAX = (ADDR_BYTES > MAX_LEN) ? ADDR_BYTES : MAX_LEN;
    localparam int unsigned IW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t state;
    state_t state_next;

    logic [IW-1:0]           idx;
    logic                    req_q;
    logic                    oe_q;
    logic                    done_q;
    logic [8*MAX_LEN-1:0]    rdata_q;
    logic [8*ADDR_BYTES-1:0] cap_addr;
    logic [8*MAX_LEN-1:0]    cap_wdata;
    logic                    cap_io;
    logic                    cap_write;
    logic [LW-1:0]           cap_len;
    logic [LW-1:0]           len_clamped;

    logic active;
    logic accept;
    logic hs;
    logic last_addr;
    logic last_data;
    logic want_oe;

    always_comb begin
        if (memory_len == '0) begin
            len_clamped = LW'(1);
        end else if (memory_len > LW'(MAX_LEN)) begin
            len_clamped = LW'(MAX_LEN);
        end else begin
            len_clamped = memory_len;
        end
    end

    assign active    = (state != IDLE);
    assign accept    = (state == IDLE) && !done_q && (memory_read || memory_write);
    assign hs        = req_q && bus_handshake_ack;
    assign last_addr = (32'(idx) == ADDR_BYTES - 1);
    assign last_data = (32'(idx) + 1 == 32'(cap_len));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = ADDR;
            ADDR:    if (hs && last_addr) state_next = DATA;
            DATA:    if (hs && last_data) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Phase outputs decoded from state and byte index
    always_comb begin
        want_oe      = 1'b0;
        bus_state    = 2'b00;
        bus_data_out = '0;
        bus_io       = memory_io;
        unique case (state)
            ADDR: begin
                want_oe      = 1'b1;
                bus_state    = (idx == '0) ? 2'b00 : 2'b01;
                bus_data_out = 8'(cap_addr >> {idx, 3'b000});
                bus_io       = cap_io;
            end
            DATA: begin
                want_oe      = cap_write;
                bus_state    = {1'b1, cap_write};
                bus_data_out = 8'(cap_wdata >> {idx, 3'b000});
                bus_io       = cap_io;
            end
            default: ;
        endcase
    end

    // Handshake, enable, capture and read-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            req_q     <= 1'b0;
            oe_q      <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_io    <= 1'b0;
            cap_write <= 1'b0;
            cap_len   <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                cap_addr  <= memory_addr;
                cap_wdata <= memory_wdata;
                cap_io    <= memory_io;
                cap_write <= !memory_read;
                cap_len   <= len_clamped;
                idx       <= '0;
            end else if (active) begin
                if (hs) begin
                    req_q <= 1'b0;
                    if (state == ADDR) begin
                        if (last_addr) begin
                            idx <= '0;
                            // Reads turn the driver off on the same edge so it is never on for a read req
                            if (!cap_write) oe_q <= 1'b0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        if (!cap_write) begin
                            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                                if (idx == IW'(i)) rdata_q[8*i +: 8] <= bus_data_in;
                            end
                        end
                        if (last_data) begin
                            idx    <= '0;
                            oe_q   <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end else if (!bus_handshake_ack) begin
                    oe_q <= want_oe;
                    // req waits one cycle after any enable change so the bus settles first
                    if (!req_q && (oe_q == want_oe)) req_q <= 1'b1;
                end
            end
        end
    end

    assign bus_handshake_req = req_q;
    assign bus_output_enable = oe_q;
    assign memory_done       = done_q;
    assign memory_rdata      = rdata_q;

endmodule

// File: tb/tb_bus_if_burst.sv
// Directed bench for bus_if_burst: a responding device with programmable ack delay
// logs every byte phase at req rise; expectations are hand-computed constants.
module tb_bus_if_burst;

    localparam int unsigned AB = 2;
    localparam int unsigned ML = 4;
    localparam int unsigned LW = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              bus_handshake_ack = 1'b0;
    logic              bus_handshake_req;
    logic [1:0]        bus_state;
    logic [7:0]        bus_data_in = 8'h00;
    logic [7:0]        bus_data_out;
    logic              bus_output_enable;
    logic              bus_io;
    logic              memory_read = 1'b0;
    logic              memory_write = 1'b0;
    logic [8*AB-1:0]   memory_addr = '0;
    logic              memory_io = 1'b0;
    logic [LW-1:0]     memory_len = '0;
    logic [8*ML-1:0]   memory_wdata = '0;
    logic [8*ML-1:0]   memory_rdata;
    logic              memory_done;

    bus_if_burst #(.ADDR_BYTES(AB), .MAX_LEN(ML)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus_handshake_ack (bus_handshake_ack),
        .bus_handshake_req (bus_handshake_req),
        .bus_state         (bus_state),
        .bus_data_in       (bus_data_in),
        .bus_data_out      (bus_data_out),
        .bus_output_enable (bus_output_enable),
        .bus_io            (bus_io),
        .memory_read       (memory_read),
        .memory_write      (memory_write),
        .memory_addr       (memory_addr),
        .memory_io         (memory_io),
        .memory_len        (memory_len),
        .memory_wdata      (memory_wdata),
        .memory_rdata      (memory_rdata),
        .memory_done       (memory_done)
    );

    always #5 clk = ~clk;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Device model and phase logger
    logic [1:0] log_state[$];
    logic [7:0] log_data[$];
    logic       log_oe[$];
    logic [7:0] dev_bytes[8];
    int         data_total = 0;
    int         done_total = 0;
    int         viol_ack = 0;
    int         viol_hold = 0;
    int         wait_cnt = 0;
    int         ack_delay = 1;
    int         dev_base = 0;
    int         base = 0;
    int         done_base = 0;
    logic       prev_req = 1'b0;
    logic       prev_oe = 1'b0;
    logic [1:0] prev_state = 2'b00;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            bus_handshake_ack = 1'b0;
            wait_cnt = 0;
            prev_req = 1'b0;
        end else begin
            if (bus_handshake_req && !prev_req) begin
                if (bus_handshake_ack) viol_ack++;
                log_state.push_back(bus_state);
                log_data.push_back(bus_data_out);
                log_oe.push_back(bus_output_enable);
                if (bus_state == 2'b10) begin
                    bus_data_in = dev_bytes[(data_total - dev_base) % 8];
                    data_total++;
                end
                wait_cnt = 0;
            end
            if (prev_req && bus_handshake_req &&
                (bus_output_enable != prev_oe || bus_state != prev_state || bus_data_out != prev_data))
                viol_hold++;
            if (memory_done) done_total++;
            if (bus_handshake_req && !bus_handshake_ack) begin
                wait_cnt++;
                if (wait_cnt >= ack_delay) bus_handshake_ack = 1'b1;
            end else if (!bus_handshake_req) begin
                bus_handshake_ack = 1'b0;
            end
            prev_req   = bus_handshake_req;
            prev_oe    = bus_output_enable;
            prev_state = bus_state;
            prev_data  = bus_data_out;
        end
    end

    task automatic go(input bit rd, input bit wr, input bit io, input logic [15:0] addr,
                      input logic [LW-1:0] len, input logic [31:0] wdata,
                      input bit hold, input bit scramble);
        @(negedge clk);
        base         = log_state.size();
        dev_base     = data_total;
        done_base    = done_total;
        memory_read  = rd;
        memory_write = wr;
        memory_io    = io;
        memory_addr  = addr;
        memory_len   = len;
        memory_wdata = wdata;
        @(negedge clk);
        if (scramble) begin
            memory_addr  = 16'hFFFF;
            memory_wdata = '0;
            memory_len   = 3'd1;
            memory_io    = ~io;
        end
        if (!hold) begin
            memory_read  = 1'b0;
            memory_write = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!memory_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(memory_done), 32'd1);
    endtask

    task automatic check_phase(input string tag, input int k, input logic [1:0] st,
                               input logic [7:0] d, input logic oe, input bit chk_d);
        check({tag, "_state"}, 32'(log_state[base + k]), 32'(st));
        if (chk_d) check({tag, "_data"}, 32'(log_data[base + k]), 32'(d));
        check({tag, "_oe"}, 32'(log_oe[base + k]), 32'(oe));
    endtask

    initial begin
        int n;
        foreach (dev_bytes[i]) dev_bytes[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_req",   32'(bus_handshake_req), 32'd0);
        check("rst_oe",    32'(bus_output_enable), 32'd0);
        check("rst_done",  32'(memory_done), 32'd0);
        check("rst_rdata", memory_rdata, 32'h0);
        check("rst_state", 32'(bus_state), 32'd0);

        // Read 0x1234, len 2, ack one cycle after req
        ack_delay = 1;
        dev_bytes[0] = 8'hAA;
        dev_bytes[1] = 8'hBB;
        go(1'b1, 1'b0, 1'b0, 16'h1234, 3'd2, 32'h0, 1'b0, 1'b0);
        wait_done("t1_done", 100);
        check("t1_done_oe", 32'(bus_output_enable), 32'd0);
        check("t1_nphase", 32'(log_state.size() - base), 32'd4);
        check_phase("t1_p0", 0, 2'b00, 8'h34, 1'b1, 1'b1);
        check_phase("t1_p1", 1, 2'b01, 8'h12, 1'b1, 1'b1);
        check_phase("t1_p2", 2, 2'b10, 8'h00, 1'b0, 1'b0);
        check_phase("t1_p3", 3, 2'b10, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_rdata", memory_rdata, 32'h0000BBAA);
        check("t1_ndone", 32'(done_total - done_base), 32'd1);

        // Write 0x00FF, len 4
        go(1'b0, 1'b1, 1'b1, 16'h00FF, 3'd4, 32'h44332211, 1'b0, 1'b0);
        wait_done("t2_done", 200);
        check("t2_done_oe", 32'(bus_output_enable), 32'd0);
        check("t2_nphase", 32'(log_state.size() - base), 32'd6);
        check_phase("t2_p0", 0, 2'b00, 8'hFF, 1'b1, 1'b1);
        check_phase("t2_p1", 1, 2'b01, 8'h00, 1'b1, 1'b1);
        check_phase("t2_p2", 2, 2'b11, 8'h11, 1'b1, 1'b1);
        check_phase("t2_p3", 3, 2'b11, 8'h22, 1'b1, 1'b1);
        check_phase("t2_p4", 4, 2'b11, 8'h33, 1'b1, 1'b1);
        check_phase("t2_p5", 5, 2'b11, 8'h44, 1'b1, 1'b1);
        @(negedge clk);
        check("t2_rdata_kept", memory_rdata, 32'h0000BBAA);

        // Length 0 -> one byte, length 7 -> clamped to four
        dev_bytes[0] = 8'h5A;
        go(1'b1, 1'b0, 1'b0, 16'h0010, 3'd0, 32'h0, 1'b0, 1'b0);
        wait_done("t3a_done", 100);
        check("t3a_nphase", 32'(log_state.size() - base), 32'd3);
        @(negedge clk);
        check("t3a_rdata", memory_rdata, 32'h0000BB5A);
        dev_bytes[0] = 8'h01; dev_bytes[1] = 8'h02; dev_bytes[2] = 8'h03; dev_bytes[3] = 8'h04;
        dev_bytes[4] = 8'h05;
        go(1'b1, 1'b0, 1'b0, 16'h0020, 3'd7, 32'h0, 1'b0, 1'b0);
        wait_done("t3b_done", 200);
        check("t3b_nphase", 32'(log_state.size() - base), 32'd6);
        @(negedge clk);
        check("t3b_rdata", memory_rdata, 32'h04030201);

        // Request inputs scrambled after acceptance
        go(1'b0, 1'b1, 1'b1, 16'h0102, 3'd2, 32'h0000BEEF, 1'b0, 1'b1);
        check("t4_io_captured", 32'(bus_io), 32'd1);
        wait_done("t4_done", 100);
        check("t4_nphase", 32'(log_state.size() - base), 32'd4);
        check_phase("t4_p0", 0, 2'b00, 8'h02, 1'b1, 1'b1);
        check_phase("t4_p1", 1, 2'b01, 8'h01, 1'b1, 1'b1);
        check_phase("t4_p2", 2, 2'b11, 8'hEF, 1'b1, 1'b1);
        check_phase("t4_p3", 3, 2'b11, 8'hBE, 1'b1, 1'b1);
        @(negedge clk);
        check("t4_ndone", 32'(done_total - done_base), 32'd1);

        // Reset during the second address phase
        ack_delay = 20;
        go(1'b1, 1'b0, 1'b0, 16'hA55A, 3'd1, 32'h0, 1'b0, 1'b0);
        n = 0;
        while (log_state.size() - base < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_reach_a1", 32'(log_state.size() - base), 32'd2);
        check("t5_a1_state", 32'(bus_state), 32'd1);
        check("t5_a1_req", 32'(bus_handshake_req), 32'd1);
        rst = 1'b1;
        memory_io = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_req", 32'(bus_handshake_req), 32'd0);
        check("t5_oe", 32'(bus_output_enable), 32'd0);
        check("t5_state", 32'(bus_state), 32'd0);
        check("t5_io_idle", 32'(bus_io), 32'd1);
        check("t5_rdata", memory_rdata, 32'h0);
        repeat (5) @(negedge clk);
        check("t5_no_done", 32'(done_total - done_base), 32'd0);
        check("t5_req_idle", 32'(bus_handshake_req), 32'd0);
        ack_delay = 1;
        dev_bytes[0] = 8'hC3;
        go(1'b1, 1'b0, 1'b0, 16'h0304, 3'd1, 32'h0, 1'b0, 1'b0);
        wait_done("t5_fresh_done", 100);
        check("t5_nphase", 32'(log_state.size() - base), 32'd3);
        check_phase("t5_p0", 0, 2'b00, 8'h04, 1'b1, 1'b1);
        check_phase("t5_p1", 1, 2'b01, 8'h03, 1'b1, 1'b1);
        check_phase("t5_p2", 2, 2'b10, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("t5_fresh_rdata", memory_rdata, 32'h000000C3);

        // Read held high across done, slow device
        ack_delay = 5;
        dev_bytes[0] = 8'h11;
        go(1'b1, 1'b0, 1'b0, 16'h0042, 3'd1, 32'h0, 1'b1, 1'b0);
        wait_done("t6_done1", 300);
        n = 0;
        while (!bus_output_enable && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t6_restart_gap", 32'(n), 32'd3);
        wait_done("t6_done2", 300);
        memory_read = 1'b0;
        @(negedge clk);
        check("t6_ndone", 32'(done_total - done_base), 32'd2);
        repeat (4) @(negedge clk);
        check("t6_idle_req", 32'(bus_handshake_req), 32'd0);

        check("req_rise_with_ack", 32'(viol_ack), 32'd0);
        check("hold_while_req", 32'(viol_hold), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bus_if_burst.md
BUS_IF_BURST -- requirements
Module: bus_if_burst

Interface
REQ-001 SHALL have parameter ADDR_BYTES, default 2, number of address bytes sent per transaction (legal range 1..4).
REQ-002 SHALL have parameter MAX_LEN, default 4, maximum data bytes per transaction (legal range 1..8); LW = $clog2(MAX_LEN+1).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port bus_handshake_ack  input  1  external ack of four-phase handshake.
REQ-006 SHALL have port bus_handshake_req  output  1  request of four-phase handshake, registered.
REQ-007 SHALL have port bus_state  output  2  phase code: 00 first address byte, 01 later address byte, 10 read data, 11 write data.
REQ-008 SHALL have port bus_data_in  input  8  byte from bus on read data phase.
REQ-009 SHALL have port bus_data_out  output  8  byte driven to bus: address byte or write data.
REQ-010 SHALL have port bus_output_enable  output  1  bus driver enable, registered.
REQ-011 SHALL have port bus_io  output  1  I/O-space flag of active transaction.
REQ-012 SHALL have ports memory_read, memory_write  input  1 each  transaction requests.
REQ-013 SHALL have port memory_addr  input  8*ADDR_BYTES  address, byte 0 sent first.
REQ-014 SHALL have port memory_io  input  1  I/O-space flag of request.
REQ-015 SHALL have port memory_len  input  LW  data byte count; 0 treated as 1, values > MAX_LEN clamped to MAX_LEN.
REQ-016 SHALL have port memory_wdata  input  8*MAX_LEN  write bytes, byte i in bits [8i+7:8i].
REQ-017 SHALL have port memory_rdata  output  8*MAX_LEN  read bytes, same packing.
REQ-018 SHALL have port memory_done  output  1  one-cycle completion pulse.

Function
REQ-019 SHALL implement states IDLE, ADDR, DATA with a byte index counter.
REQ-020 SHALL, in IDLE with memory_done low and memory_read or memory_write high, accept the request and capture addr, io, clamped len, direction and wdata into registers; read has priority if both high.
REQ-021 SHALL use only captured values after acceptance; request inputs may change or deassert without affecting the active transaction.
REQ-022 SHALL emit ADDR_BYTES address phases (index 0..ADDR_BYTES-1), then len data phases, one full req/ack handshake per byte.
REQ-023 SHALL drive bus_state 00 for address index 0, 01 for index >=1, {1,write} in DATA; bus_data_out = address byte or wdata byte[index], don't-care otherwise.
REQ-024 SHALL compute want_oe = ADDR or (DATA and write); while active and ack low, bus_output_enable <= want_oe.
REQ-025 SHALL raise req only when active, ack low, req low, and bus_output_enable already equals want_oe (at least one cycle after any OE change).
REQ-026 SHALL hold req, bus_state, bus_data_out and bus_output_enable stable while req is high.
REQ-027 SHALL, on cycle with req and ack both high, drop req and advance index/state; next req waits for ack low.
REQ-028 SHALL, on final address ack of a read, clear bus_output_enable in the same edge so OE is never high during a read-data req.
REQ-029 SHALL, on read-data ack for byte i, latch bus_data_in into memory_rdata byte i; bytes >= len keep previous value.
REQ-030 SHALL, on final data ack, return to IDLE, clear bus_output_enable, pulse memory_done for exactly one cycle.
REQ-031 SHALL not accept a new request in the cycle memory_done is high; earliest new acceptance is the following cycle.
REQ-032 SHALL drive bus_io from captured io while active and from memory_io in IDLE.

Reset
REQ-033 SHALL, with rst high at a rising edge, set state IDLE, index 0, bus_handshake_req 0, bus_output_enable 0, memory_done 0, memory_rdata 0, captured registers 0.
REQ-034 SHALL abort any in-flight transaction on reset without a memory_done pulse; req falls at that edge regardless of ack.

Verification
REQ-035 Read, addr 0x1234, len 2, device acks 1 cycle after req -> bus_state 00/01/10/10 with data_out 0x34,0x12; data 0xAA,0xBB -> rdata[15:0]=0xBBAA, one done pulse, OE low during both data reqs.
REQ-036 Write, addr 0x00FF, len 4, wdata 0x44332211 -> data phases code 11 with bytes 0x11,0x22,0x33,0x44, OE high through all phases, done then OE 0.
REQ-037 memory_len 0 and memory_len 7 -> exactly 1 and 4 data phases respectively.
REQ-038 Change memory_addr/memory_wdata and drop memory_write after acceptance -> bus sequence matches captured values, done still pulses.
REQ-039 Assert rst while req high in second address phase -> next cycle req 0, OE 0, state IDLE, no done; fresh read then completes normally.
REQ-040 Hold memory_read high after done, ack delayed 5 cycles per phase -> no acceptance on done cycle, new transaction starts next cycle, req never rises while ack high.
